// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// A grant holds for up to MAX_BURST words, then priority rotates to the next requester.

module fifo_wr_arbiter_lane #(
  parameter int ID_WIDTH = 1,
  parameter int LANE     = 0
) (
  input  logic                i_xfer,
  input  logic [ID_WIDTH-1:0] i_grant_id,
  output logic                o_ready
);
  localparam logic [ID_WIDTH-1:0] LANE_ID = ID_WIDTH'(LANE);

  assign o_ready = i_xfer && (i_grant_id == LANE_ID);
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_we,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_full,
  input  logic                          fifo_re,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);
  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [ID_WIDTH-1:0]  LAST_ID  = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_BURST - 1);

  state_t                             r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]                r_rr_ptr, w_rr_nxt;
  logic [ID_WIDTH-1:0]                r_grant_id, w_grant_nxt;
  logic [CNT_WIDTH-1:0]               r_burst_cnt, w_cnt_nxt;
  logic [ID_WIDTH-1:0]                w_winner;
  logic                               w_hit;
  logic                               w_gnt_valid;
  logic                               w_xfer;
  logic                               w_release;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] w_slice;

  assign w_slice     = req_data;
  assign w_gnt_valid = req_valid[r_grant_id];
  // A write coinciding with a FIFO read is dropped by the FIFO, so hold it off.
  assign w_xfer      = (r_state == BURST) && w_gnt_valid && !fifo_full && !fifo_re;
  assign w_release   = !w_gnt_valid && !fifo_full && !fifo_re;

  assign fifo_we    = w_xfer;
  assign fifo_wdata = w_slice[r_grant_id];
  assign grant_id   = r_grant_id;
  assign busy       = (r_state == BURST);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      fifo_wr_arbiter_lane #(
        .ID_WIDTH (ID_WIDTH),
        .LANE     (gi)
      ) u_lane (
        .i_xfer     (w_xfer),
        .i_grant_id (r_grant_id),
        .o_ready    (req_ready[gi])
      );
    end
  endgenerate

  // Descending scan so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    w_hit    = 1'b0;
    w_winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_hit    = 1'b1;
        w_winner = ID_WIDTH'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_cnt_nxt   = r_burst_cnt;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          w_grant_nxt = w_winner;
          w_cnt_nxt   = '0;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        if (w_xfer) w_cnt_nxt = r_burst_cnt + 1'b1;
        if ((w_xfer && (r_burst_cnt == LAST_CNT)) || w_release) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_grant_id  <= w_grant_nxt;
      r_burst_cnt <= w_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: two queue-backed producers, hand-computed per-cycle expectations.

module tb_fifo_wr_arbiter;
  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        fifo_we;
  logic [31:0] fifo_wdata;
  logic        fifo_full;
  logic        fifo_re;
  logic [0:0]  grant_id;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int nwrites = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  fifo_wr_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(32), .ID_WIDTH(1), .MAX_BURST(4), .CNT_WIDTH(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_we    (fifo_we),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .fifo_re    (fifo_re),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_valid[0]    = (q0.size() > 0);
    req_valid[1]    = (q1.size() > 0);
    req_data[31:0]  = (q0.size() > 0) ? q0[0] : 32'h0;
    req_data[63:32] = (q1.size() > 0) ? q1[0] : 32'h0;
  endtask

  // One cycle: drive, check outputs mid-cycle, clock, retire any accepted word.
  task automatic step(input logic ewe, input logic egid, input logic ebusy,
                      input logic [31:0] edat, input string tag);
    logic [1:0] rdy;
    logic [1:0] erdy;
    drive();
    #1;
    erdy = 2'b00;
    if (ewe) erdy[egid] = 1'b1;
    chk({31'b0, fifo_we},  {31'b0, ewe},   {tag, ".we"});
    chk({31'b0, grant_id}, {31'b0, egid},  {tag, ".gid"});
    chk({31'b0, busy},     {31'b0, ebusy}, {tag, ".busy"});
    chk({30'b0, req_ready}, {30'b0, erdy}, {tag, ".ready"});
    if (ewe) chk(fifo_wdata, edat, {tag, ".data"});
    if (fifo_we) nwrites++;
    rdy = req_ready;
    @(posedge clk);
    #1;
    if (rdy[0]) void'(q0.pop_front());
    if (rdy[1]) void'(q1.pop_front());
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b0;
    fifo_full = 1'b0;
    fifo_re   = 1'b0;
    for (int i = 0; i < 9; i++) q0.push_back(32'hA000_0000 + i);
    for (int i = 0; i < 8; i++) q1.push_back(32'hB000_0000 + i);
    drive();

    // Reset state with both requesters pending
    @(negedge clk);
    #1;
    chk({31'b0, fifo_we},   32'd0, "rst.we");
    chk({30'b0, req_ready}, 32'd0, "rst.ready");
    chk({31'b0, busy},      32'd0, "rst.busy");
    chk({31'b0, grant_id},  32'd0, "rst.gid");
    @(negedge clk);
    reset = 1'b1;

    // Test 1: reset mid-burst, then requester 0 first
    step(0, 0, 0, 0, "t1.idle");
    step(1, 0, 1, 32'hA000_0000, "t1.w0");
    reset = 1'b0;
    drive();
    #1;
    chk({31'b0, fifo_we},   32'd0, "t1.rst.we");
    chk({30'b0, req_ready}, 32'd0, "t1.rst.ready");
    chk({31'b0, busy},      32'd0, "t1.rst.busy");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Test 3: continuous 2'b11 -> grants 0,1,0,1 in bursts of 4
    step(0, 0, 0, 0, "t3.idle0");
    for (int i = 1; i <= 4; i++) step(1, 0, 1, 32'hA000_0000 + i, "t3.g0a");
    step(0, 0, 0, 0, "t3.idle1");
    for (int i = 0; i < 4; i++)  step(1, 1, 1, 32'hB000_0000 + i, "t3.g1a");
    step(0, 1, 0, 0, "t3.idle2");
    for (int i = 5; i <= 8; i++) step(1, 0, 1, 32'hA000_0000 + i, "t3.g0b");
    step(0, 0, 0, 0, "t3.idle3");
    for (int i = 4; i < 8; i++)  step(1, 1, 1, 32'hB000_0000 + i, "t3.g1b");
    step(0, 1, 0, 0, "t3.empty");

    // Test 2: 6 words on requester 0 -> gap, 4 writes, idle, 2 writes
    for (int i = 0; i < 6; i++) q0.push_back(32'hC000_0000 + i);
    step(0, 1, 0, 0, "t2.idle0");
    for (int i = 0; i < 4; i++) step(1, 0, 1, 32'hC000_0000 + i, "t2.burst");
    step(0, 0, 0, 0, "t2.idle1");
    step(1, 0, 1, 32'hC000_0004, "t2.w4");
    step(1, 0, 1, 32'hC000_0005, "t2.w5");
    step(0, 0, 1, 0, "t2.release");
    step(0, 0, 0, 0, "t2.idle2");

    // Test 4: fifo_full for 3 cycles mid-burst; burst still totals 4
    for (int i = 0; i < 4; i++) q0.push_back(32'hD000_0000 + i);
    step(0, 0, 0, 0, "t4.idle");
    step(1, 0, 1, 32'hD000_0000, "t4.w0");
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "t4.full");
    fifo_full = 1'b0;
    for (int i = 1; i < 4; i++) step(1, 0, 1, 32'hD000_0000 + i, "t4.resume");
    step(0, 0, 0, 0, "t4.done");

    // Test 5: fifo_re withholds a write for one cycle
    for (int i = 0; i < 3; i++) q1.push_back(32'hE000_0000 + i);
    step(0, 0, 0, 0, "t5.idle");
    step(1, 1, 1, 32'hE000_0000, "t5.w0");
    fifo_re = 1'b1;
    step(0, 1, 1, 0, "t5.re");
    fifo_re = 1'b0;
    step(1, 1, 1, 32'hE000_0001, "t5.w1");
    step(1, 1, 1, 32'hE000_0002, "t5.w2");
    step(0, 1, 1, 0, "t5.release");
    step(0, 1, 0, 0, "t5.done");

    // Test 6: requester 1 drops valid after 2 words; requester 0 next
    q1.push_back(32'hF000_0000);
    q1.push_back(32'hF000_0001);
    step(0, 1, 0, 0, "t6.idle");
    q0.push_back(32'h6000_0000);
    q0.push_back(32'h6000_0001);
    step(1, 1, 1, 32'hF000_0000, "t6.w0");
    step(1, 1, 1, 32'hF000_0001, "t6.w1");
    step(0, 1, 1, 0, "t6.drop");
    step(0, 1, 0, 0, "t6.idle2");
    step(1, 0, 1, 32'h6000_0000, "t6.r0w0");
    step(1, 0, 1, 32'h6000_0001, "t6.r0w1");
    step(0, 0, 1, 0, "t6.release");
    step(0, 0, 0, 0, "t6.done");

    chk(nwrites, 32'd34, "total.writes");
    chk(q0.size() + q1.size(), 32'd0, "queues.drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
